// File: rtl/ahb_arb_pkg.sv
// Shared constants and one-hot/index helpers for the 5-master AHB-Lite arbiter.
package ahb_arb_pkg;

    localparam int NM     = 5;
    localparam int MIDX_W = 3;

    function automatic logic [NM-1:0] onehot5(input logic [MIDX_W-1:0] idx);
        onehot5 = 5'b00001 << idx;
    endfunction

    function automatic logic [MIDX_W-1:0] idx5(input logic [NM-1:0] oh);
        idx5 = '0;
        for (int i = 0; i < NM; i++) begin
            if (oh[i]) idx5 = MIDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/ahb_arb5_rr_pick5.sv
// Combinational round-robin picker: scans ptr+1 .. ptr+4 (mod 5), checks ptr itself last.
import ahb_arb_pkg::*;

module rr_pick5 (
    input  logic [NM-1:0]     req,
    input  logic [MIDX_W-1:0] ptr,
    output logic [MIDX_W-1:0] gnt_idx,
    output logic              any_req
);

    always_comb begin
        logic              found;
        logic [MIDX_W-1:0] cidx;
        gnt_idx = ptr;
        any_req = |req;
        found   = 1'b0;
        cidx    = '0;
        for (int k = 1; k <= NM; k++) begin
            cidx = MIDX_W'((int'(ptr) + k) % NM);
            if (!found && req[cidx]) begin
                gnt_idx = cidx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arb5.sv
// Round-robin AHB-Lite arbiter for 5 masters with hold limit, locked transfers and
// one-hot address/data-phase selects feeding AND-OR bus muxes.
import ahb_arb_pkg::*;

module ahb_arb5 #(
    parameter int DEF_M    = 0,
    parameter int MAX_HOLD = 8
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [NM-1:0]     hreq,
    input  logic [NM-1:0]     hlock,
    input  logic              hready,
    output logic [NM-1:0]     addr_sel,
    output logic [NM-1:0]     data_sel,
    output logic [MIDX_W-1:0] hmaster,
    output logic              hmastlock
);

    localparam logic [MIDX_W-1:0] DEF_IDX   = MIDX_W'(DEF_M);
    localparam logic [7:0]        HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [MIDX_W-1:0] owner_p0;
    logic [NM-1:0]     data_sel_p1;
    logic [7:0]        hold_cnt_p0;

    logic              own_req;
    logic              own_lock;
    logic              arb_ok;
    logic [MIDX_W-1:0] pick_idx;
    logic              any_req;
    logic [MIDX_W-1:0] next_owner;

    assign own_req  = hreq[owner_p0];
    assign own_lock = hlock[owner_p0];

    // A locked, requesting owner can never reach arb_ok through the hold limit.
    assign arb_ok = hready & (~own_req | (~own_lock & (hold_cnt_p0 == HOLD_LAST)));

    rr_pick5 u_pick (
        .req     (hreq),
        .ptr     (owner_p0),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    assign next_owner = any_req ? pick_idx : DEF_IDX;

    // Address phase (p0) and data phase (p1) ownership
    always_ff @(posedge hclk) begin
        if (hreset) begin
            owner_p0    <= DEF_IDX;
            data_sel_p1 <= onehot5(DEF_IDX);
            hold_cnt_p0 <= '0;
        end else if (hready) begin
            data_sel_p1 <= onehot5(owner_p0);
            if (arb_ok) begin
                owner_p0    <= next_owner;
                hold_cnt_p0 <= '0;
            end else if (own_req && hold_cnt_p0 != HOLD_LAST) begin
                hold_cnt_p0 <= hold_cnt_p0 + 8'd1;
            end
        end
    end

    assign addr_sel  = onehot5(owner_p0);
    assign data_sel  = data_sel_p1;
    assign hmaster   = owner_p0;
    assign hmastlock = ~hreset & own_lock & own_req;

    a_sel_onehot : assert property (@(posedge hclk) disable iff (hreset)
        $onehot(addr_sel) && $onehot(data_sel));

endmodule

// File: tb/tb_ahb_arb5.sv
// Directed bench for ahb_arb5 (DEF_M=0, MAX_HOLD=4) with hand-computed expectations.
`timescale 1ns/1ps

module tb_ahb_arb5;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [4:0] hreq;
    logic [4:0] hlock;
    logic       hready;
    logic [4:0] addr_sel;
    logic [4:0] data_sel;
    logic [2:0] hmaster;
    logic       hmastlock;

    int total = 0;
    int bad   = 0;

    always #5 hclk = ~hclk;

    ahb_arb5 #(.DEF_M(0), .MAX_HOLD(4)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hreq      (hreq),
        .hlock     (hlock),
        .hready    (hready),
        .addr_sel  (addr_sel),
        .data_sel  (data_sel),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset = 1'b1;
        hreq   = 5'b00000;
        hlock  = 5'b00000;
        hready = 1'b1;

        // Reset
        tick();
        tick();
        chk("rst_lock_in_reset", 8'(hmastlock), 8'h0);
        chk("rst_addr_sel", 8'(addr_sel), 8'h01);
        chk("rst_data_sel", 8'(data_sel), 8'h01);
        chk("rst_hmaster", 8'(hmaster), 8'h0);
        hreset = 1'b0;
        #1;
        chk("rst_hmastlock", 8'(hmastlock), 8'h0);

        // Single request
        hreq = 5'b00100;
        tick();
        chk("single_addr_sel", 8'(addr_sel), 8'h04);
        chk("single_hmaster", 8'(hmaster), 8'h2);
        chk("single_data_lag", 8'(data_sel), 8'h01);
        tick();
        chk("single_data_sel", 8'(data_sel), 8'h04);

        // RR wrap
        hreq = 5'b10011;
        tick();
        chk("rr_grant4", 8'(hmaster), 8'h4);
        hreq = 5'b00011;
        tick();
        chk("rr_grant0", 8'(hmaster), 8'h0);
        hreq = 5'b00010;
        tick();
        chk("rr_grant1", 8'(hmaster), 8'h1);

        // Hold limit, unlocked owner 0
        hreq = 5'b00001;
        tick();
        chk("hold_get0", 8'(hmaster), 8'h0);
        hreq = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_keep0", 8'(hmaster), 8'h0);
        end
        tick();
        chk("hold_switch1", 8'(hmaster), 8'h1);

        // Hold limit, locked owner 0
        hreq = 5'b00001;
        tick();
        chk("lock_get0", 8'(hmaster), 8'h0);
        hreq  = 5'b00011;
        hlock = 5'b00001;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("lock_keep0", 8'(hmaster), 8'h0);
            chk("lock_hmastlock", 8'(hmastlock), 8'h1);
        end

        // Wait states
        hlock = 5'b00000;
        hreq  = 5'b00010;
        tick();
        chk("ws_get1", 8'(hmaster), 8'h1);
        tick();
        chk("ws_data1", 8'(data_sel), 8'h02);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) hreq = 5'b01000;
            tick();
            chk("ws_addr_frozen", 8'(addr_sel), 8'h02);
            chk("ws_data_frozen", 8'(data_sel), 8'h02);
        end
        hready = 1'b1;
        tick();
        chk("ws_switch3", 8'(addr_sel), 8'h08);
        chk("ws_data_after", 8'(data_sel), 8'h02);

        // Reset mid-burst: owner 3 locked, hold count at 2
        hreq  = 5'b01000;
        hlock = 5'b01000;
        tick();
        tick();
        chk("mid_lock_on", 8'(hmastlock), 8'h1);
        chk("mid_owner3", 8'(hmaster), 8'h3);
        hreset = 1'b1;
        #1;
        chk("mid_lock_forced", 8'(hmastlock), 8'h0);
        tick();
        chk("mid_addr_sel", 8'(addr_sel), 8'h01);
        chk("mid_data_sel", 8'(data_sel), 8'h01);
        chk("mid_hmastlock", 8'(hmastlock), 8'h0);
        hreset = 1'b0;
        hreq   = 5'b00011;
        hlock  = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_cnt_cleared", 8'(hmaster), 8'h0);
        end
        tick();
        chk("mid_switch1", 8'(hmaster), 8'h1);

        // Park on default master when idle
        hreq = 5'b00000;
        tick();
        chk("park_def", 8'(addr_sel), 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
